// File: rtl/wb_master_port_if.sv
// Bundle of CPU request/response and Wishbone signals for wb_master_port.
// master: the initiator side (wb_master_port); slave: the CPU + bus side.
interface wb_master_port_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // CPU request / response
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic                    req_we_i;
    logic [ADDR_WIDTH-1:0]   req_addr_i;
    logic [DATA_WIDTH-1:0]   req_wdata_i;
    logic [1:0]              req_size_i;
    logic                    req_unsigned_i;
    logic                    rsp_valid_o;
    logic [DATA_WIDTH-1:0]   rsp_rdata_o;
    logic                    rsp_err_o;
    // Wishbone classic
    logic                    wb_cyc_o;
    logic                    wb_stb_o;
    logic                    wb_ack_i;
    logic [ADDR_WIDTH-1:0]   wb_adr_o;
    logic [DATA_WIDTH-1:0]   wb_dat_o;
    logic [DATA_WIDTH-1:0]   wb_dat_i;
    logic [DATA_WIDTH/8-1:0] wb_sel_o;
    logic                    wb_we_o;

    modport master (
        input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
        input  wb_ack_i, wb_dat_i
    );

    modport slave (
        output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_size_i, req_unsigned_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  wb_cyc_o, wb_stb_o, wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o,
        output wb_ack_i, wb_dat_i
    );
endinterface

// File: rtl/wb_master_port.sv
// Wishbone classic initiator: turns byte/half/word load/store requests into
// word-aligned single bus cycles and returns an extended load result.
// Optional bus timeout is built when the macro WB_TIMEOUT_EN is defined.
module wb_master_port #(
    parameter int DATA_WIDTH     = 32,   // only 32 is supported
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    wb_master_port_if.master  bus
);
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

    localparam int SEL_W = DATA_WIDTH / 8;

    state_t                  state_q, state_d;
    logic                    we_q, we_d;          // captured request direction
    logic [1:0]              lane_q, lane_d;      // captured addr[1:0]
    logic [1:0]              size_q, size_d;
    logic                    uns_q, uns_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   wdat_q, wdat_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic                    wbwe_q, wbwe_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                    rsp_err_q, rsp_err_d;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0]        cnt_q, cnt_d;
`else
    // Timeout limit is irrelevant when the bus may stall indefinitely.
    logic                    unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

    // Request-side decode of the incoming access
    logic                    req_illegal;
    logic [1:0]              req_lane;
    logic [SEL_W-1:0]        req_sel;
    logic [DATA_WIDTH-1:0]   req_dat;
    // Load-side lane extraction of the slave data
    logic [DATA_WIDTH-1:0]   rd_shifted;
    logic [DATA_WIDTH-1:0]   rd_ext;

    assign bus.req_ready_o = (state_q == S_IDLE);
    assign bus.wb_cyc_o    = cyc_q;
    assign bus.wb_stb_o    = stb_q;
    assign bus.wb_adr_o    = adr_q;
    assign bus.wb_dat_o    = wdat_q;
    assign bus.wb_sel_o    = sel_q;
    assign bus.wb_we_o     = wbwe_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.rsp_rdata_o = rsp_rdata_q;
    assign bus.rsp_err_o   = rsp_err_q;

    // Decode alignment, byte selects and replicated write data for a new request
    always_comb begin
        req_lane    = bus.req_addr_i[1:0];
        req_illegal = 1'b0;
        req_sel     = '0;
        req_dat     = bus.req_wdata_i;
        case (bus.req_size_i)
            2'b00: begin
                req_sel = SEL_W'(4'b0001 << req_lane);
                req_dat = {4{bus.req_wdata_i[7:0]}};
            end
            2'b01: begin
                req_illegal = req_lane[0];
                req_sel     = SEL_W'(4'b0011 << req_lane);
                req_dat     = {2{bus.req_wdata_i[15:0]}};
            end
            2'b10: begin
                req_illegal = (req_lane != 2'b00);
                req_sel     = 4'b1111;
            end
            default: req_illegal = 1'b1;
        endcase
    end

    // Move the addressed lane down to bit 0 and extend it to full width
    always_comb begin
        rd_shifted = bus.wb_dat_i >> {lane_q, 3'b000};
        rd_ext     = rd_shifted;
        case (size_q)
            2'b00:   rd_ext = uns_q ? {24'd0, rd_shifted[7:0]}
                                    : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01:   rd_ext = uns_q ? {16'd0, rd_shifted[15:0]}
                                    : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            default: rd_ext = rd_shifted;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        lane_d      = lane_q;
        size_d      = size_q;
        uns_d       = uns_q;
        cyc_d       = cyc_q;
        stb_d       = stb_q;
        adr_d       = adr_q;
        wdat_d      = wdat_q;
        sel_d       = sel_q;
        wbwe_d      = wbwe_q;
        // Response fields are a one-cycle pulse; they fall back to 0 by default.
        rsp_valid_d = 1'b0;
        rsp_rdata_d = '0;
        rsp_err_d   = 1'b0;
`ifdef WB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid_i) begin
                    we_d   = bus.req_we_i;
                    lane_d = req_lane;
                    size_d = bus.req_size_i;
                    uns_d  = bus.req_unsigned_i;
                    if (req_illegal) begin
                        // Rejected locally: the bus never sees this access.
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = S_BUS;
                        cyc_d   = 1'b1;
                        stb_d   = 1'b1;
                        wbwe_d  = bus.req_we_i;
                        adr_d   = {bus.req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                        sel_d   = req_sel;
                        wdat_d  = req_dat;
`ifdef WB_TIMEOUT_EN
                        cnt_d   = '0;
`endif
                    end
                end
            end
            S_BUS: begin
                if (bus.wb_ack_i) begin
                    // Ack takes priority over a coincident timeout.
                    state_d     = S_RESP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = we_q ? '0 : rd_ext;
                end
`ifdef WB_TIMEOUT_EN
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d     = S_RESP;
                    cyc_d       = 1'b0;
                    stb_d       = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any bus cycle immediately
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            lane_q      <= 2'b00;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            adr_q       <= '0;
            wdat_q      <= '0;
            sel_q       <= '0;
            wbwe_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
`ifdef WB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            lane_q      <= lane_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            cyc_q       <= cyc_d;
            stb_q       <= stb_d;
            adr_q       <= adr_d;
            wdat_q      <= wdat_d;
            sel_q       <= sel_d;
            wbwe_q      <= wbwe_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
`ifdef WB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_wb_master_port.sv
// Directed bench for wb_master_port: table of load/store vectors plus
// hand-written reset, stray-ack and (with WB_TIMEOUT_EN) timeout sequences.
module tb_wb_master_port;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk_i = ~clk_i;

    wb_master_port_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_if ();

    wb_master_port #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus_if.master)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        int          delay;      // cycles before ack is driven
        logic [31:0] bus_rdata;  // slave data presented with ack
        logic        exp_bus;    // a bus cycle is expected
        logic [3:0]  exp_sel;
        logic [31:0] exp_adr;
        logic [31:0] exp_dat;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        bus_if.req_valid_i    = 1'b0;
        bus_if.req_we_i       = 1'b0;
        bus_if.req_addr_i     = '0;
        bus_if.req_wdata_i    = '0;
        bus_if.req_size_i     = 2'b00;
        bus_if.req_unsigned_i = 1'b0;
        bus_if.wb_ack_i       = 1'b0;
        bus_if.wb_dat_i       = 32'h5A5A_5A5A;
    endtask

    // Run one request to completion and compare bus and response behaviour
    task automatic do_txn(input int idx, input vec_t v);
        @(negedge clk_i);
        bus_if.req_valid_i    = 1'b1;
        bus_if.req_we_i       = v.we;
        bus_if.req_addr_i     = v.addr;
        bus_if.req_wdata_i    = v.wdata;
        bus_if.req_size_i     = v.size;
        bus_if.req_unsigned_i = v.uns;
        @(posedge clk_i); #1;
        check("ready_low_after_accept", {31'd0, bus_if.req_ready_o}, 32'd0);
        if (v.exp_bus) begin
            check("cyc_after_accept", {31'd0, bus_if.wb_cyc_o}, 32'd1);
            check("stb_after_accept", {31'd0, bus_if.wb_stb_o}, 32'd1);
            check("wb_adr", bus_if.wb_adr_o, v.exp_adr);
            check("wb_sel", {28'd0, bus_if.wb_sel_o}, {28'd0, v.exp_sel});
            check("wb_dat_o", bus_if.wb_dat_o, v.exp_dat);
            check("wb_we", {31'd0, bus_if.wb_we_o}, {31'd0, v.we});
            // Requester keeps valid high with a different request; must be ignored.
            bus_if.req_addr_i = 32'hFFFF_FFF0;
            bus_if.req_size_i = 2'b10;
            for (int i = 0; i < v.delay; i++) begin
                @(negedge clk_i);
                bus_if.wb_ack_i = 1'b0;
                bus_if.wb_dat_i = 32'h0F0F_0F0F ^ i;
                @(posedge clk_i); #1;
                check("cyc_held", {31'd0, bus_if.wb_cyc_o}, 32'd1);
                check("adr_held", bus_if.wb_adr_o, v.exp_adr);
                check("no_rsp_in_wait", {31'd0, bus_if.rsp_valid_o}, 32'd0);
            end
            @(negedge clk_i);
            bus_if.req_valid_i = 1'b0;
            bus_if.wb_ack_i    = 1'b1;
            bus_if.wb_dat_i    = v.bus_rdata;
            @(posedge clk_i); #1;
            bus_if.wb_ack_i    = 1'b0;
            bus_if.wb_dat_i    = 32'hFFFF_FFFF;
            check("cyc_drop_on_ack", {31'd0, bus_if.wb_cyc_o}, 32'd0);
            check("stb_drop_on_ack", {31'd0, bus_if.wb_stb_o}, 32'd0);
        end else begin
            bus_if.req_valid_i = 1'b0;
            check("no_cyc_illegal", {31'd0, bus_if.wb_cyc_o}, 32'd0);
        end
        check("rsp_valid", {31'd0, bus_if.rsp_valid_o}, 32'd1);
        check("rsp_rdata", bus_if.rsp_rdata_o, v.exp_rdata);
        check("rsp_err", {31'd0, bus_if.rsp_err_o}, {31'd0, v.exp_err});
        $display("txn %0d: we=%0b addr=0x%08h size=%0d rdata=0x%08h err=%0b",
                 idx, v.we, v.addr, v.size, bus_if.rsp_rdata_o, bus_if.rsp_err_o);
        @(posedge clk_i); #1;
        check("rsp_pulse_ends", {31'd0, bus_if.rsp_valid_o}, 32'd0);
        check("rsp_rdata_clears", bus_if.rsp_rdata_o, 32'd0);
        check("ready_back", {31'd0, bus_if.req_ready_o}, 32'd1);
    endtask

    initial begin
        //            we    addr          wdata         sz     uns  dly bus_rdata     bus   sel      adr           dat           rdata         err
        vecs[0]  = '{1'b1, 32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 1'b0, 3, 32'h0,        1'b1, 4'b1111, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b0, 32'h0000_0103, 32'h0,         2'b00, 1'b0, 1, 32'h80AA_BBCC, 1'b1, 4'b1000, 32'h0000_0100, 32'h0,         32'hFFFF_FF80, 1'b0};
        vecs[2]  = '{1'b0, 32'h0000_0103, 32'h0,         2'b00, 1'b1, 0, 32'h80AA_BBCC, 1'b1, 4'b1000, 32'h0000_0100, 32'h0,         32'h0000_0080, 1'b0};
        vecs[3]  = '{1'b1, 32'h0000_0202, 32'h0000_A5A5, 2'b01, 1'b0, 0, 32'h0,        1'b1, 4'b1100, 32'h0000_0200, 32'hA5A5_A5A5, 32'h0,        1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0202, 32'h0,         2'b01, 1'b1, 2, 32'h1234_ABCD, 1'b1, 4'b1100, 32'h0000_0200, 32'h0,         32'h0000_1234, 1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0101, 32'h0,         2'b00, 1'b0, 0, 32'h1122_8344, 1'b1, 4'b0010, 32'h0000_0100, 32'h0,         32'hFFFF_FF83, 1'b0};
        vecs[6]  = '{1'b0, 32'h0000_0200, 32'h0,         2'b01, 1'b0, 1, 32'h0000_8001, 1'b1, 4'b0011, 32'h0000_0200, 32'h0,         32'hFFFF_8001, 1'b0};
        vecs[7]  = '{1'b0, 32'h0000_0304, 32'h0,         2'b10, 1'b0, 0, 32'hCAFE_F00D, 1'b1, 4'b1111, 32'h0000_0304, 32'h0,         32'hCAFE_F00D, 1'b0};
        vecs[8]  = '{1'b1, 32'h0000_0001, 32'h1234_5678, 2'b00, 1'b0, 1, 32'hFFFF_FFFF, 1'b1, 4'b0010, 32'h0000_0000, 32'h7878_7878, 32'h0,        1'b0};
        vecs[9]  = '{1'b0, 32'h0000_0101, 32'h0,         2'b10, 1'b0, 0, 32'h0,        1'b0, 4'b0000, 32'h0,         32'h0,         32'h0,        1'b1};
        vecs[10] = '{1'b0, 32'h0000_0100, 32'h0,         2'b11, 1'b0, 0, 32'h0,        1'b0, 4'b0000, 32'h0,         32'h0,         32'h0,        1'b1};
        vecs[11] = '{1'b0, 32'h0000_0203, 32'h0,         2'b01, 1'b1, 0, 32'h0,        1'b0, 4'b0000, 32'h0,         32'h0,         32'h0,        1'b1};
        vecs[12] = '{1'b1, 32'h0000_0102, 32'h1111_2222, 2'b10, 1'b0, 0, 32'h0,        1'b0, 4'b0000, 32'h0,         32'h0,         32'h0,        1'b1};

        idle_inputs();
        // Reset state
        #2;
        check("reset_ready", {31'd0, bus_if.req_ready_o}, 32'd1);
        check("reset_cyc", {31'd0, bus_if.wb_cyc_o}, 32'd0);
        check("reset_rsp_valid", {31'd0, bus_if.rsp_valid_o}, 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_i = 1'b0;

        // Stray ack while idle must not produce anything
        bus_if.wb_ack_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;
        check("stray_ack_no_rsp", {31'd0, bus_if.rsp_valid_o}, 32'd0);
        check("stray_ack_no_cyc", {31'd0, bus_if.wb_cyc_o}, 32'd0);
        bus_if.wb_ack_i = 1'b0;

        for (int i = 0; i < NV; i++) do_txn(i, vecs[i]);

        // Asynchronous reset in the middle of a stalled bus cycle
        @(negedge clk_i);
        bus_if.req_valid_i = 1'b1;
        bus_if.req_we_i    = 1'b0;
        bus_if.req_addr_i  = 32'h0000_0400;
        bus_if.req_size_i  = 2'b10;
        @(posedge clk_i); #1;
        bus_if.req_valid_i = 1'b0;
        check("midreset_cyc_before", {31'd0, bus_if.wb_cyc_o}, 32'd1);
        @(posedge clk_i); #3;
        rst_i = 1'b1;
        #1;
        check("midreset_cyc", {31'd0, bus_if.wb_cyc_o}, 32'd0);
        check("midreset_stb", {31'd0, bus_if.wb_stb_o}, 32'd0);
        check("midreset_rsp", {31'd0, bus_if.rsp_valid_o}, 32'd0);
        check("midreset_ready", {31'd0, bus_if.req_ready_o}, 32'd1);
        check("midreset_adr", bus_if.wb_adr_o, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("midreset_no_late_rsp", {31'd0, bus_if.rsp_valid_o}, 32'd0);
        do_txn(100, vecs[1]);

`ifdef WB_TIMEOUT_EN
        // No ack: bus cycle aborted after 8 BUS cycles with an error
        @(negedge clk_i);
        bus_if.req_valid_i = 1'b1;
        bus_if.req_we_i    = 1'b0;
        bus_if.req_addr_i  = 32'h0000_0800;
        bus_if.req_size_i  = 2'b10;
        @(posedge clk_i); #1;
        bus_if.req_valid_i = 1'b0;
        for (int i = 0; i < 7; i++) begin
            check("to_cyc_held", {31'd0, bus_if.wb_cyc_o}, 32'd1);
            @(posedge clk_i); #1;
        end
        check("to_cyc_still_8th", {31'd0, bus_if.wb_cyc_o}, 32'd1);
        @(posedge clk_i); #1;
        check("to_cyc_drop", {31'd0, bus_if.wb_cyc_o}, 32'd0);
        check("to_rsp_valid", {31'd0, bus_if.rsp_valid_o}, 32'd1);
        check("to_rsp_err", {31'd0, bus_if.rsp_err_o}, 32'd1);
        check("to_rsp_rdata", bus_if.rsp_rdata_o, 32'd0);
        $display("txn timeout: err=%0b", bus_if.rsp_err_o);
        @(posedge clk_i); #1;
        // Ack in the 8th BUS cycle beats the timeout
        do_txn(101, '{1'b0, 32'h0000_0800, 32'h0, 2'b10, 1'b0, 7, 32'h1357_9BDF,
                      1'b1, 4'b1111, 32'h0000_0800, 32'h0, 32'h1357_9BDF, 1'b0});
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
